// File: rtl/fb_pkg.sv
// fb_pkg: screen geometry, colour constants and receiver FSM states shared by the pixel write path.
package fb_pkg;
    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_ADDR_W = 17;

    localparam logic [2:0] C_BLACK   = 3'b000;
    localparam logic [2:0] C_BLUE    = 3'b001;
    localparam logic [2:0] C_GREEN   = 3'b010;
    localparam logic [2:0] C_CYAN    = 3'b011;
    localparam logic [2:0] C_RED     = 3'b100;
    localparam logic [2:0] C_MAGENTA = 3'b101;
    localparam logic [2:0] C_YELLOW  = 3'b110;
    localparam logic [2:0] C_WHITE   = 3'b111;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/pixel_write_receiver_if.sv
// pixel_write_receiver_if: draw-side pixel input, clear control and framebuffer write port.
interface pixel_write_receiver_if #(
    parameter int ADDR_W = fb_pkg::FB_ADDR_W
);
    logic [9:0]        x;
    logic [9:0]        y;
    logic [2:0]        color;
    logic              writeEn;
    logic              ready;
    logic              clear;
    logic              clearing;
    logic              clear_done;
    logic              overflow;
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_data;
    logic              fb_we;
    logic              fb_ready;

    modport master (
        output x, y, color, writeEn, clear, fb_ready,
        input  ready, clearing, clear_done, overflow, fb_addr, fb_data, fb_we
    );

    modport slave (
        input  x, y, color, writeEn, clear, fb_ready,
        output ready, clearing, clear_done, overflow, fb_addr, fb_data, fb_we
    );
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO of {x, y, color} pixels with same-cycle push/pop.
module pixel_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = r_count == (AW + 1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rp];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge clk)
        if (w_wr)
            r_mem[r_wp] <= i_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_rd)
                r_rp <= r_rp + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end
endmodule

// File: rtl/pixel_write_receiver.sv
// pixel_write_receiver: clips and colour-keys incoming pixels, buffers them and issues
// linear framebuffer writes on a valid/ready port; also sweeps the whole screen on clear.
module pixel_write_receiver #(
    parameter int         SCREEN_W    = fb_pkg::SCREEN_W,
    parameter int         SCREEN_H    = fb_pkg::SCREEN_H,
    parameter int         ADDR_W      = fb_pkg::FB_ADDR_W,
    parameter int         FIFO_DEPTH  = 8,
    parameter bit         KEY_EN      = 1'b1,
    parameter logic [2:0] KEY_COLOR   = fb_pkg::C_BLACK,
    parameter logic [2:0] CLEAR_COLOR = fb_pkg::C_BLACK
) (
    input logic                   clk,
    input logic                   reset_n,
    pixel_write_receiver_if.slave bus
);
    import fb_pkg::state_t, fb_pkg::S_RUN, fb_pkg::S_CLEAR;

    localparam int TOTAL = SCREEN_W * SCREEN_H;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic              w_qual;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_load;
    logic              w_go;
    logic [22:0]       w_head;
    logic [CW-1:0]     w_count;
    state_t            r_state;
    logic              r_clr_pend;
    logic              r_we;
    logic              r_done;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_data;
    logic [ADDR_W:0]   r_cnt;

    assign w_qual = bus.writeEn && 32'(bus.x) < SCREEN_W && 32'(bus.y) < SCREEN_H &&
                    !(KEY_EN && bus.color == KEY_COLOR);
    assign w_push = w_qual && !w_full;
    assign w_load = !r_we || bus.fb_ready;
    // A clear waits until the output register is free, so a pending pixel is never lost.
    assign w_go   = r_state == S_RUN && (bus.clear || r_clr_pend) && w_load;
    assign w_pop  = r_state == S_RUN && !w_go && w_load && !w_empty;

    pixel_fifo #(
        .WIDTH (23),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset_n),
        .i_push  (w_push),
        .i_data  ({bus.x, bus.y, bus.color}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state    <= S_RUN;
            r_clr_pend <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            r_ovf  <= r_ovf || (w_qual && w_full);
            if (r_state == S_RUN) begin
                r_clr_pend <= (r_clr_pend || bus.clear) && !w_go;
                if (w_go) begin
                    r_state <= S_CLEAR;
                    r_cnt   <= '0;
                    r_we    <= 1'b0;
                end else if (w_load) begin
                    r_we <= !w_empty;
                    if (!w_empty) begin
                        r_addr <= ADDR_W'(32'(w_head[12:3]) * 32'(SCREEN_W) + 32'(w_head[22:13]));
                        r_data <= w_head[2:0];
                    end
                end
            end else if (w_load) begin
                // Sweep: each free/transferring slot takes the next address until all are issued.
                if (32'(r_cnt) < TOTAL) begin
                    r_we   <= 1'b1;
                    r_addr <= r_cnt[ADDR_W-1:0];
                    r_data <= CLEAR_COLOR;
                    r_cnt  <= r_cnt + 1'b1;
                end else begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_RUN;
                end
            end
        end
    end

    assign bus.ready      = 32'(w_count) < FIFO_DEPTH;
    assign bus.clearing   = r_state == S_CLEAR;
    assign bus.clear_done = r_done;
    assign bus.overflow   = r_ovf;
    assign bus.fb_addr    = r_addr;
    assign bus.fb_data    = r_data;
    assign bus.fb_we      = r_we;
endmodule

// File: tb/tb_pixel_write_receiver.sv
// tb_pixel_write_receiver: table vectors, hand sequences for backpressure/clear/reset,
// and a randomized run checked against a queue-based scoreboard.
module tb_pixel_write_receiver;
    localparam int W     = 320;
    localparam int H     = 240;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pixel_write_receiver_if #(.ADDR_W(17)) bus ();

    pixel_write_receiver dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
        bit q;
        int addr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int c, input bit we);
        bus.x       = 10'(x);
        bus.y       = 10'(y);
        bus.color   = 3'(c);
        bus.writeEn = we;
    endtask

    function automatic bit qual(input int x, input int y, input int c);
        return x < W && y < H && c != 0;
    endfunction

    function automatic logic [19:0] expw(input int x, input int y, input int c);
        return {17'(y * W + x), 3'(c)};
    endfunction

    // Scoreboard: accepted pixels queue up in order; every transfer must match the head.
    bit          mon_en = 1'b0;
    bit          exp_ovf = 1'b0;
    logic [19:0] exp_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            check("overflow", bus.overflow, exp_ovf);
            if (bus.ready)
                check("ready_bound", exp_q.size() <= DEPTH, 1);
            else
                check("notready_bound", exp_q.size() >= DEPTH, 1);
            if (exp_q.size() == 0)
                check("idle_we", bus.fb_we, 0);
            if (bus.fb_we && bus.fb_ready) begin
                if (exp_q.size() == 0)
                    check("spurious_xfer", 1, 0);
                else
                    check("xfer", {bus.fb_addr, bus.fb_data}, exp_q.pop_front());
            end
            if (bus.writeEn && qual(int'(bus.x), int'(bus.y), int'(bus.color))) begin
                if (bus.ready)
                    exp_q.push_back(expw(int'(bus.x), int'(bus.y), int'(bus.color)));
                else
                    exp_ovf = 1'b1;
            end
        end
    end

    initial begin
        vec_t        tbl[9];
        logic [19:0] bp[10];
        logic [19:0] pw;
        int          n, first, idx, serr, dones, done_at;
        bit          post;
        logic [19:0] got;

        drive(0, 0, 0, 0);
        bus.clear    = 1'b0;
        bus.fb_ready = 1'b1;
        repeat (3) step();
        reset_n = 1'b0;
        check("rst_fb_we", bus.fb_we, 0);
        check("rst_fb_addr", bus.fb_addr, 0);
        check("rst_fb_data", bus.fb_data, 0);
        check("rst_clearing", bus.clearing, 0);
        check("rst_clear_done", bus.clear_done, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_ready", bus.ready, 1);

        tbl = '{
            '{5, 2, 6, 1'b1, 645},
            '{320, 0, 7, 1'b0, 0},
            '{0, 240, 7, 1'b0, 0},
            '{10, 10, 0, 1'b0, 0},
            '{319, 239, 1, 1'b1, 76799},
            '{0, 0, 1, 1'b1, 0},
            '{1023, 1023, 5, 1'b0, 0},
            '{319, 0, 7, 1'b1, 319},
            '{0, 1, 4, 1'b1, 320}
        };
        foreach (tbl[i]) begin
            n = 0;
            first = -1;
            got = '0;
            drive(tbl[i].x, tbl[i].y, tbl[i].c, 1'b1);
            step();
            bus.writeEn = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (bus.fb_we && bus.fb_ready) begin
                    n++;
                    if (first < 0)
                        first = k;
                    got = {bus.fb_addr, bus.fb_data};
                end
                step();
            end
            check($sformatf("vec%0d_count", i), n, tbl[i].q ? 1 : 0);
            if (tbl[i].q) begin
                check($sformatf("vec%0d_latency", i), first, 1);
                check($sformatf("vec%0d_word", i), got, {17'(tbl[i].addr), 3'(tbl[i].c)});
            end
        end
        check("clip_key_overflow", bus.overflow, 0);

        // Backpressure: output register plus full FIFO retain the first DEPTH+1 pixels.
        bus.fb_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            bp[i] = expw(i + 20, i + 1, (i % 7) + 1);
            drive(i + 20, i + 1, (i % 7) + 1, 1'b1);
            step();
        end
        bus.writeEn = 1'b0;
        check("bp_ready", bus.ready, 0);
        check("bp_overflow", bus.overflow, 1);
        for (int k = 0; k < 3; k++) begin
            check("bp_stall_we", bus.fb_we, 1);
            check("bp_stall_word", {bus.fb_addr, bus.fb_data}, bp[0]);
            step();
        end
        bus.fb_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.fb_we && bus.fb_ready) begin
                if (n < 10)
                    check($sformatf("bp_out%0d", n), {bus.fb_addr, bus.fb_data}, bp[n]);
                n++;
            end
            step();
        end
        check("bp_retained", n, DEPTH + 1);

        // Clear sweep with a mid-sweep pixel and an ignored second clear pulse.
        idx = 0;
        serr = 0;
        dones = 0;
        done_at = -1;
        post = 1'b0;
        pw = '0;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        for (int c = 0; c < 80000 && !post; c++) begin
            if (c == 500)
                drive(3, 0, 2, 1'b1);
            else
                bus.writeEn = 1'b0;
            bus.clear = (c == 1000);
            if (bus.clear_done) begin
                dones++;
                done_at = idx;
            end
            if (bus.fb_we && bus.fb_ready) begin
                if (idx < W * H) begin
                    if ({bus.fb_addr, bus.fb_data} !== {17'(idx), 3'b000} || !bus.clearing)
                        serr++;
                    idx++;
                end else begin
                    pw = {bus.fb_addr, bus.fb_data};
                    post = 1'b1;
                end
            end
            step();
        end
        bus.clear = 1'b0;
        check("clr_count", idx, W * H);
        check("clr_seq_errs", serr, 0);
        check("clr_done_pulses", dones, 1);
        check("clr_done_at", done_at, W * H);
        check("clr_post_pixel", pw, expw(3, 0, 2));
        check("clr_clearing_after", bus.clearing, 0);
        check("clr_overflow_sticky", bus.overflow, 1);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            n += bus.fb_we;
            step();
        end
        check("clr_no_second_sweep", n, 0);

        // Reset in the middle of a sweep with pixels buffered.
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        repeat (50) step();
        for (int i = 0; i < 4; i++) begin
            drive(i + 50, 7, 3, 1'b1);
            step();
        end
        bus.writeEn = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        reset_n = 1'b0;
        check("mrst_fb_we", bus.fb_we, 0);
        check("mrst_clearing", bus.clearing, 0);
        check("mrst_ready", bus.ready, 1);
        check("mrst_overflow", bus.overflow, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            n += bus.fb_we;
            step();
        end
        check("mrst_no_emit", n, 0);

        // Random throttle against the scoreboard.
        exp_q.delete();
        exp_ovf = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bus.fb_ready = 1'($urandom % 2);
            drive(int'($urandom_range(0, 335)), int'($urandom_range(0, 250)),
                  int'($urandom % 8), ($urandom % 10) < 7);
            step();
        end
        bus.writeEn = 1'b0;
        bus.fb_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++)
            step();
        step();
        mon_en = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_idle_we", bus.fb_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_write_receiver.md
Name: pixel_write_receiver

Overview:
- Consumer end of the pixel-write interface driven by the sprite/ship/asteroid draw modules (x, y, colour, writeEn).
- Accepts one pixel per cycle, clips it to the screen, drops colour-keyed pixels and buffers the rest in a small FIFO.
- Converts each buffered pixel to a linear framebuffer address and presents it on a valid/ready write port toward the framebuffer/VGA arbiter.
- Also runs a full-screen clear sweep on command.

Parameters:
- SCREEN_W, 320: visible columns; accepted x range is 0..SCREEN_W-1.
- SCREEN_H, 240: visible rows; accepted y range is 0..SCREEN_H-1.
- ADDR_W, 17: framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.
- FIFO_DEPTH, 8: pixel FIFO entries; must be a power of two, minimum 2.
- KEY_EN, 1: when 1, pixels with colour == KEY_COLOR are dropped (transparency).
- KEY_COLOR, 3'b000: transparent colour.
- CLEAR_COLOR, 3'b000: colour written by the clear sweep.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset_n  in  1  synchronous, ACTIVE-HIGH reset despite the name (1 = reset), sampled on posedge clk.
- x  in  10  pixel column from the draw module.
- y  in  10  pixel row from the draw module.
- color  in  3  pixel colour.
- writeEn  in  1  pixel valid this cycle; no backpressure toward the producer.
- ready  out  1  FIFO not full; informational to the producer.
- clear  in  1  single-cycle pulse; starts a clear sweep.
- clearing  out  1  high while the sweep is active.
- clear_done  out  1  one-cycle pulse after the last clear write transfers.
- overflow  out  1  sticky; set when a pixel that passed clip/key checks arrives while the FIFO is full.
- fb_addr  out  ADDR_W  framebuffer write address.
- fb_data  out  3  framebuffer write colour.
- fb_we  out  1  write valid; held until transferred.
- fb_ready  in  1  framebuffer accepts the write; a transfer occurs when fb_we && fb_ready.

Behaviour:
- Reset (reset_n=1), applied at any time including mid-sweep or with a non-empty FIFO:
  - FIFO emptied; state goes to S_RUN.
  - fb_we=0, fb_addr=0, fb_data=0, clearing=0, clear_done=0, overflow=0.
  - ready=1 from the first cycle after reset.
- Input filter (combinational on the input side):
  - A pixel qualifies when writeEn=1 and x<SCREEN_W and y<SCREEN_H and !(KEY_EN && color==KEY_COLOR).
  - Non-qualifying pixels are silently discarded and never set overflow.
- Push:
  - A qualifying pixel is written to the FIFO when ready=1. ready = !full, based on the registered count.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - A refused qualifying pixel is lost and sets overflow; overflow clears only on reset.
  - Push and pop in the same cycle leave the count unchanged.
- Output register (fb_addr/fb_data/fb_we):
  - Loads when it is empty or transferring (fb_we=0 or fb_ready=1).
  - In S_RUN it loads from the FIFO head when the FIFO is non-empty.
  - Address = y*SCREEN_W + x, computed at full width, then truncated to ADDR_W.
  - Latency: a pixel pushed at edge N into an empty FIFO appears on the port after edge N+1, with fb_we=1.
  - Throughput: 1 pixel per cycle while fb_ready=1.
  - While fb_we=1 and fb_ready=0, fb_addr and fb_data are stable.
- FSM:
  - S_RUN: drain the FIFO. On a clear pulse, go to S_CLEAR after the output register has transferred any pending write. The clear is remembered until then.
  - S_CLEAR:
    - clearing=1. The output register is driven by an internal counter from 0 to SCREEN_W*SCREEN_H-1, with fb_data=CLEAR_COLOR.
    - The counter advances on each transfer. The FIFO is not drained, but pushes continue.
    - After the last address transfers, pulse clear_done and return to S_RUN.
    - The pixels buffered during the sweep are then emitted in arrival order.
  - A clear pulse received during S_CLEAR is ignored. Clear plus a simultaneous writeEn: the pixel is queued and drawn after the sweep.
- Ordering: FIFO order is preserved; there is no reordering or merging of writes to the same address.

Decomposition:
- Shared package `fb_pkg`:
  - constants SCREEN_W, SCREEN_H, FB_ADDR_W;
  - colour constants (C_BLACK=3'b000, C_RED=3'b100, ...);
  - FSM state localparams S_RUN and S_CLEAR.
- One sub-module `pixel_fifo`:
  - synchronous FIFO, width 23 ({x, y, color}), depth FIFO_DEPTH;
  - provides full, empty and count, with same-cycle push/pop support.
- The top level holds the filter, FSM, clear counter and output register.

Test Plan:
- Single pixel: after reset, drive x=5, y=2, color=3'b110, writeEn=1 for 1 cycle with fb_ready=1 → exactly one transfer, fb_addr=645, fb_data=6, fb_we high 1 cycle starting one edge after the push.
- Clip and key: drive (320,0,3'b111), (0,240,3'b111) and (10,10,3'b000) → no fb_we, overflow stays 0. Then drive (319,239,3'b001) → fb_addr=76799.
- Backpressure: hold fb_ready=0 and push 10 distinct pixels over consecutive cycles → 8 buffered, ready=0 after the 8th (output register may hold 1 more, so 9 retained total); overflow=1. After releasing fb_ready, the retained pixels emerge in order with stable data while stalled.
- Clear: pulse clear with fb_ready=1 → addresses 0..76799 in order with data 3'b000, clearing high throughout, clear_done pulses once. A pixel (3,0,3'b010) pushed mid-sweep is written as addr 3, data 2 after clear_done.
- Reset mid-operation: assert reset_n=1 for 1 cycle mid-sweep with 4 pixels buffered → next cycle fb_we=0, clearing=0, ready=1, overflow=0, and no buffered pixel is ever emitted.
- Random throttle: random fb_ready at 50% and random qualifying pixels → a scoreboard checks every transferred (addr, data) matches accepted pixels in order, and that drops occur only when ready=0.
